// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration sequencer.
// AXI tie-offs live here so the parent can drive the constant channel fields.
package cgra_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    FINISH
  } state_t;

  localparam logic [7:0]  AXI_LEN        = 8'd0;
  localparam logic [2:0]  AXI_SIZE       = 3'b011;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [7:0]  AXI_STRB       = 8'hFF;
  localparam logic [3:0]  AXI_ID         = 4'd0;
  localparam logic        AXI_WLAST      = 1'b1;

  localparam logic [1:0]  RESP_OKAY      = 2'b00;

  localparam logic [63:0] DEF_POLL_ADDR  = 64'h5000_0058;
  localparam logic [63:0] DEF_DONE_MASK  = 64'h1;

endpackage

// File: rtl/cgra_cfg_sequencer.sv
// Replays a table of single-beat AXI writes into the CGRA window, then polls a
// status register until the done mask is set; one transaction outstanding at a time.
module cgra_cfg_sequencer
  import cgra_cfg_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    MAX_CMDS     = 8,
  parameter logic [ADDR_WIDTH-1:0] POLL_ADDR    = ADDR_WIDTH'(DEF_POLL_ADDR),
  parameter logic [DATA_WIDTH-1:0] DONE_MASK    = DATA_WIDTH'(DEF_DONE_MASK),
  parameter int                    POLL_TIMEOUT = 256,
  localparam int                   CNT_W        = $clog2(MAX_CMDS + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           start_i,
  input  logic [CNT_W-1:0]               num_cmds_i,
  input  logic [MAX_CMDS*ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [MAX_CMDS*DATA_WIDTH-1:0] cmd_data_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic                           aw_valid_o,
  input  logic                           aw_ready_i,
  output logic [ADDR_WIDTH-1:0]          aw_addr_o,
  output logic                           w_valid_o,
  input  logic                           w_ready_i,
  output logic [DATA_WIDTH-1:0]          w_data_o,
  input  logic                           b_valid_i,
  output logic                           b_ready_o,
  input  logic [1:0]                     b_resp_i,
  output logic                           ar_valid_o,
  input  logic                           ar_ready_i,
  output logic [ADDR_WIDTH-1:0]          ar_addr_o,
  input  logic                           r_valid_i,
  output logic                           r_ready_o,
  input  logic [DATA_WIDTH-1:0]          r_data_i,
  input  logic [1:0]                     r_resp_i
);

  localparam int POLL_W = $clog2(POLL_TIMEOUT + 1);

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, idx, cnt_clamped, idx_inc, wr_idx;
  logic [POLL_W-1:0]       poll_cnt, poll_inc;
  logic                    err_flag, finish_err;
  logic                    aw_vld, w_vld, wr_sent, poll_hit;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [DATA_WIDTH-1:0]   w_data;

  assign cnt_clamped = (num_cmds_i > CNT_W'(MAX_CMDS)) ? CNT_W'(MAX_CMDS) : num_cmds_i;
  assign idx_inc     = idx + CNT_W'(1);
  assign poll_inc    = poll_cnt + POLL_W'(1);
  assign poll_hit    = (r_data_i & DONE_MASK) == DONE_MASK;
  // A channel whose valid has already dropped has completed its handshake.
  assign wr_sent     = (!aw_vld || aw_ready_i) && (!w_vld || w_ready_i);
  assign wr_idx      = (state == IDLE) ? '0 : idx_inc;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    finish_err = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_next = (cnt_clamped == '0) ? RD_ADDR : WR_ADDR_DATA;
      end
      WR_ADDR_DATA: begin
        if (wr_sent) state_next = WR_RESP;
      end
      WR_RESP: begin
        if (b_valid_i) begin
          if (b_resp_i != RESP_OKAY) begin
            state_next = FINISH;
            finish_err = 1'b1;
          end else if (idx_inc < cnt) begin
            state_next = WR_ADDR_DATA;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (ar_ready_i) state_next = RD_DATA;
      end
      RD_DATA: begin
        if (r_valid_i) begin
          if (r_resp_i != RESP_OKAY) begin
            state_next = FINISH;
            finish_err = 1'b1;
          end else if (poll_hit) begin
            state_next = FINISH;
          end else if (poll_inc == POLL_W'(POLL_TIMEOUT)) begin
            state_next = FINISH;
            finish_err = 1'b1;
          end else begin
            state_next = RD_ADDR;
          end
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= '0;
      idx      <= '0;
      poll_cnt <= '0;
      err_flag <= 1'b0;
      aw_vld   <= 1'b0;
      w_vld    <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        cnt      <= cnt_clamped;
        idx      <= '0;
        poll_cnt <= '0;
      end
      if (state == WR_RESP && state_next == WR_ADDR_DATA) idx <= idx_inc;
      if (state == RD_DATA && r_valid_i) poll_cnt <= poll_inc;
      if (state_next == FINISH && state != FINISH) err_flag <= finish_err;

      // Each write's beat is loaded on entry so the bus never sees the table combinationally.
      if (state_next == WR_ADDR_DATA && state != WR_ADDR_DATA) begin
        aw_vld  <= 1'b1;
        w_vld   <= 1'b1;
        aw_addr <= cmd_addr_i[int'(wr_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        w_data  <= cmd_data_i[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        if (aw_vld && aw_ready_i) aw_vld <= 1'b0;
        if (w_vld && w_ready_i)   w_vld  <= 1'b0;
      end
    end
  end

  assign busy_o     = (state != IDLE);
  assign done_o     = (state == FINISH) && !err_flag;
  assign err_o      = (state == FINISH) && err_flag;
  assign aw_valid_o = aw_vld;
  assign aw_addr_o  = aw_addr;
  assign w_valid_o  = w_vld;
  assign w_data_o   = w_data;
  assign b_ready_o  = (state == WR_RESP);
  assign ar_valid_o = (state == RD_ADDR);
  assign ar_addr_o  = (state == RD_ADDR) ? POLL_ADDR : '0;
  assign r_ready_o  = (state == RD_DATA);

endmodule

// File: tb/tb_cgra_cfg_sequencer.sv
// Scoreboard bench: a reference model predicts the bus traffic and completion of each run,
// a responder plays the slave, and a monitor compares every handshake and pulse.
module tb_cgra_cfg_sequencer;
  import cgra_cfg_pkg::*;

  localparam int          MAXC  = 8;
  localparam int          CW    = $clog2(MAXC + 1);
  localparam int          TO    = 4;
  localparam logic [63:0] PADDR = 64'h5000_0058;
  localparam logic [63:0] MASK  = 64'h1;

  logic clk, rst, start;
  logic [CW-1:0] num_cmds;
  logic [MAXC*64-1:0] cmd_addr, cmd_data;
  logic busy, done, err;
  logic aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready;
  logic [63:0] aw_addr, w_data, ar_addr, r_data;
  logic [1:0] b_resp, r_resp;

  cgra_cfg_sequencer #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_CMDS(MAXC),
    .POLL_ADDR(PADDR), .DONE_MASK(MASK), .POLL_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_cmds_i(num_cmds),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .busy_o(busy), .done_o(done), .err_o(err),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_aw[$], exp_w[$], exp_ar[$];
  bit          exp_done[$];
  logic [1:0]  bq[$], rq_resp[$];
  logic [63:0] rq_data[$];

  logic [63:0] tbl_addr [MAXC];
  logic [63:0] tbl_data [MAXC];

  int aw_hold   = 0;
  int b_extra   = 0;
  bit rnd_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s: event observed, none expected", name);
  endtask

  task automatic fill_table();
    for (int k = 0; k < MAXC; k++) begin
      tbl_addr[k] = 64'h5000_0000 + 64'(k * 8 + 'h40);
      tbl_data[k] = {$urandom, $urandom};
    end
  endtask

  task automatic pack();
    for (int k = 0; k < MAXC; k++) begin
      cmd_addr[k*64 +: 64] = tbl_addr[k];
      cmd_data[k*64 +: 64] = tbl_data[k];
    end
  endtask

  // Slave responder: ready patterns, one B per completed AW+W pair, one R per AR.
  initial begin
    bit aw_got = 0, w_got = 0, b_owed = 0, r_owed = 0;
    int b_wait = 0, r_wait = 0;
    aw_ready = 0; w_ready = 0; ar_ready = 0;
    b_valid = 0; b_resp = 0; r_valid = 0; r_data = 0; r_resp = 0;
    forever begin
      @(negedge clk);
      aw_ready = (aw_hold > 0) ? 1'b0 : (rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1);
      w_ready  = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      ar_ready = rnd_ready ? ($urandom_range(0, 1) != 0) : 1'b1;
      b_valid  = b_owed && (b_wait == 0);
      b_resp   = (b_valid && bq.size() > 0) ? bq[0] : RESP_OKAY;
      r_valid  = r_owed && (r_wait == 0);
      r_data   = (r_valid && rq_data.size() > 0) ? rq_data[0] : 64'd0;
      r_resp   = (r_valid && rq_resp.size() > 0) ? rq_resp[0] : RESP_OKAY;
      #1;
      if (rst) begin
        aw_got = 0; w_got = 0; b_owed = 0; r_owed = 0; aw_hold = 0;
      end else begin
        if (aw_hold > 0 && aw_valid) aw_hold--;
        if (aw_valid && aw_ready) aw_got = 1;
        if (w_valid && w_ready) w_got = 1;
        if (b_valid && b_ready) begin
          b_owed = 0;
          if (bq.size() > 0) void'(bq.pop_front());
        end else if (b_owed && b_wait > 0) b_wait--;
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_owed = 1;
          b_wait = $urandom_range(0, 2) + b_extra;
        end
        if (r_valid && r_ready) begin
          r_owed = 0;
          if (rq_data.size() > 0) void'(rq_data.pop_front());
          if (rq_resp.size() > 0) void'(rq_resp.pop_front());
        end else if (r_owed && r_wait > 0) r_wait--;
        if (ar_valid && ar_ready) begin
          r_owed = 1;
          r_wait = $urandom_range(0, 2);
        end
      end
    end
  end

  // Monitor: every handshake and completion pulse is checked against the scoreboard.
  initial begin
    bit aw_stall = 0, w_stall = 0;
    logic [63:0] aw_prev = 0, w_prev = 0;
    forever begin
      @(negedge clk);
      #2;
      if (aw_stall && !rst) begin
        check("aw_valid_held", 64'(aw_valid), 64'd1);
        check("aw_addr_stable", aw_addr, aw_prev);
      end
      if (w_stall && !rst) begin
        check("w_valid_held", 64'(w_valid), 64'd1);
        check("w_data_stable", w_data, w_prev);
      end
      if (aw_valid && aw_ready) begin
        if (exp_aw.size() == 0) fail("aw_unexpected");
        else check("aw_addr", aw_addr, exp_aw.pop_front());
      end
      if (w_valid && w_ready) begin
        if (exp_w.size() == 0) fail("w_unexpected");
        else check("w_data", w_data, exp_w.pop_front());
      end
      if (ar_valid && ar_ready) begin
        if (exp_ar.size() == 0) fail("ar_unexpected");
        else check("ar_addr", ar_addr, exp_ar.pop_front());
      end
      if (done || err) begin
        if (exp_done.size() == 0) fail("completion_unexpected");
        else check("completion{done,err}", {62'd0, done, err}, exp_done.pop_front() ? 64'd2 : 64'd1);
        check("busy_at_finish", 64'(busy), 64'd1);
      end
      aw_stall = aw_valid && !aw_ready && !rst;
      aw_prev  = aw_addr;
      w_stall  = w_valid && !w_ready && !rst;
      w_prev   = w_data;
    end
  end

  // Reference model: predicts writes issued, polls issued and outcome from the rules alone.
  task automatic run(input int num, input int bad_b, input logic [1:0] bad_resp,
                     input int zeros, input int rmode, input bit dstart);
    int n, t;
    bit failed;
    n = (num > MAXC) ? MAXC : num;
    failed = 0;
    for (int k = 0; k < n && !failed; k++) begin
      exp_aw.push_back(tbl_addr[k]);
      exp_w.push_back(tbl_data[k]);
      if (k == bad_b) begin
        bq.push_back(bad_resp);
        failed = 1;
      end else bq.push_back(RESP_OKAY);
    end
    if (!failed) begin
      for (int p = 1; p <= TO; p++) begin
        exp_ar.push_back(PADDR);
        if (p == zeros + 1 && rmode == 2) begin
          rq_data.push_back({$urandom, $urandom});
          rq_resp.push_back(2'($urandom_range(1, 3)));
          failed = 1;
          break;
        end
        if (p == zeros + 1 && rmode == 0) begin
          rq_data.push_back({$urandom, $urandom} | MASK);
          rq_resp.push_back(RESP_OKAY);
          break;
        end
        rq_data.push_back({$urandom, $urandom} & ~MASK);
        rq_resp.push_back(RESP_OKAY);
        if (p == TO) failed = 1;
      end
    end
    exp_done.push_back(!failed);

    @(negedge clk);
    start = 1'b1;
    num_cmds = CW'(num);
    @(negedge clk);
    if (dstart) begin
      num_cmds = CW'(5);
      @(negedge clk);
    end
    start = 1'b0;

    t = 0;
    while ((busy || exp_done.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail("run_timeout");
    check("busy_after_run", 64'(busy), 64'd0);
    check("drain", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_done.size()
                      + bq.size() + rq_data.size()), 64'd0);
  endtask

  initial begin
    int t;
    rst = 1; start = 0; num_cmds = 0; cmd_addr = 0; cmd_data = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done_err", {62'd0, done, err}, 64'd0);
    check("rst_aw_w_valid", {62'd0, aw_valid, w_valid}, 64'd0);
    check("rst_ar_valid", 64'(ar_valid), 64'd0);
    check("rst_b_r_ready", {62'd0, b_ready, r_ready}, 64'd0);
    check("rst_aw_addr", aw_addr, 64'd0);
    rst = 0;

    // Single write, immediate readies, first poll hits.
    rnd_ready = 0;
    fill_table();
    tbl_addr[0] = 64'h5000_0050;
    tbl_data[0] = 64'h1;
    pack();
    run(1, -1, 2'b00, 0, 0, 0);

    // AW stalled while W is accepted.
    fill_table(); pack();
    aw_hold = 5;
    run(1, -1, 2'b00, 0, 0, 0);

    // SLVERR on the second of three writes.
    run(3, 1, 2'b10, 0, 0, 0);

    // Three misses then a hit on the last allowed poll; then a full timeout.
    run(1, -1, 2'b00, 3, 0, 0);
    run(2, -1, 2'b00, 0, 1, 0);
    // Read error on a poll; count above MAX_CMDS is clamped.
    run(0, -1, 2'b00, 1, 2, 0);
    run(12, -1, 2'b00, 0, 0, 0);

    // Reset while waiting for a write response, then a fresh run from entry 0.
    fill_table(); pack();
    b_extra = 20;
    exp_aw.push_back(tbl_addr[0]);
    exp_w.push_back(tbl_data[0]);
    @(negedge clk);
    start = 1'b1; num_cmds = CW'(3);
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!b_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) fail("wr_resp_timeout");
    rst = 1;
    repeat (2) @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_drain", 64'(exp_aw.size() + exp_w.size()), 64'd0);
    exp_aw.delete(); exp_w.delete(); bq.delete();
    rst = 0;
    b_extra = 0;
    run(3, -1, 2'b00, 1, 0, 0);

    // No writes, with a second start while busy.
    run(0, -1, 2'b00, 0, 0, 1);

    // Randomized runs with random ready patterns.
    rnd_ready = 1;
    for (int i = 0; i < 14; i++) begin
      int bad;
      fill_table(); pack();
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      run(int'($urandom_range(0, 12)), bad, 2'($urandom_range(1, 3)),
          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cgra_cfg_sequencer.md
Name:
cgra_cfg_sequencer

Overview:
- AXI4 master-side controller that configures and launches the CGRA accelerator without a CPU.
- On start it issues a list of single-beat register writes (address/data pairs) to the accelerator slave window through the crossbar.
- It then polls a status register until a done mask is set, and reports done or error.
- It drives one crossbar slave port, replacing hand-sequenced bench stimulus; valids are held until each handshake completes.

Parameters:
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data width
MAX_CMDS, 8, command table depth; counter width is $clog2(MAX_CMDS+1)
POLL_ADDR, 64'h5000_0058, status register address polled after the last write
DONE_MASK, 64'h1, poll completes when (r_data_i & DONE_MASK) == DONE_MASK
POLL_TIMEOUT, 256, maximum number of status reads before error

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
start_i  input  1  one-cycle pulse; ignored unless FSM is IDLE
num_cmds_i  input  $clog2(MAX_CMDS+1)  number of writes; sampled at start; values above MAX_CMDS are clamped to MAX_CMDS
cmd_addr_i  input  MAX_CMDS*ADDR_WIDTH  packed write addresses; entry k at [k*ADDR_WIDTH +: ADDR_WIDTH]
cmd_data_i  input  MAX_CMDS*DATA_WIDTH  packed write data, same packing as cmd_addr_i
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse on successful completion
err_o  output  1  one-cycle pulse on non-OKAY response or poll timeout
aw_valid_o  output  1  AXI AW valid
aw_ready_i  input  1  AXI AW ready
aw_addr_o  output  ADDR_WIDTH  AXI AW address
w_valid_o  output  1  AXI W valid
w_ready_i  input  1  AXI W ready
w_data_o  output  DATA_WIDTH  AXI W data
b_valid_i  input  1  AXI B valid
b_ready_o  output  1  AXI B ready
b_resp_i  input  2  AXI B response
ar_valid_o  output  1  AXI AR valid
ar_ready_i  input  1  AXI AR ready
ar_addr_o  output  ADDR_WIDTH  AXI AR address
r_valid_i  input  1  AXI R valid
r_ready_o  output  1  AXI R ready
r_data_i  input  DATA_WIDTH  AXI R data
r_resp_i  input  2  AXI R response

Behaviour:
- Constant AXI fields are tied off by the parent from package constants: len=0, size=3'b011, burst=INCR, id=0, w_strb all ones, w_last=1.
- Reset: state=IDLE; all outputs 0, including every valid and ready. Reset asserted mid-transaction aborts immediately with no completion pulse.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH.
- IDLE + start_i: latch the clamped count into cnt, clear idx and poll_cnt; go to WR_ADDR_DATA. If cnt==0, go to RD_ADDR instead.
- WR_ADDR_DATA: assert aw_valid_o and w_valid_o together with entry idx, registered (no combinational path from inputs).
  - Each valid drops the cycle after its own handshake; AW and W may complete in either order or the same cycle.
  - Once both channels have completed, go to WR_RESP.
- WR_RESP: b_ready_o=1. On b_valid_i:
  - resp!=OKAY: go to FINISH with error.
  - else idx+1<cnt: idx++ and go to WR_ADDR_DATA.
  - else: go to RD_ADDR.
- RD_ADDR: ar_valid_o=1 with POLL_ADDR; on ar_ready_i go to RD_DATA.
- RD_DATA: r_ready_o=1. On r_valid_i, poll_cnt++, then:
  - r_resp_i!=OKAY: error.
  - mask matched: success.
  - poll_cnt reached POLL_TIMEOUT: error.
  - otherwise: go to RD_ADDR.
- FINISH: pulse done_o or err_o for one cycle, then return to IDLE. At most one write or read is outstanding at a time.
- start_i while busy has no effect. Entries for the current run must stay stable while busy_o is high.

Decomposition:
- Package cgra_cfg_pkg holds: state enum; AXI tie-off constants (len, size, burst, strb, id); RESP_OKAY; default POLL_ADDR and DONE_MASK.
- No sub-module; single FSM plus idx and poll counters.

Test Plan:
1. num_cmds=1, entry0=(0x5000_0050, 0x1), AW/W ready immediately, B OKAY, first poll returns 0x1 -> exactly one AW and one W beat with those values, one AR to 0x5000_0058, done_o pulses once, busy_o low after.
2. aw_ready held low 5 cycles while w_ready is high -> W completes first; aw_valid stays high with the address unchanged until accepted; only one beat per channel is issued.
3. num_cmds=3, B for entry 1 = SLVERR -> entry 2 is never issued, no AR is issued, err_o pulses once.
4. Poll returns 0x0 three times, then 0x1 -> 4 ARs issued, done_o pulses after the 4th R. With POLL_TIMEOUT=4 and all reads returning 0 -> err_o pulses after the 4th R.
5. rst_i asserted during WR_RESP, then start_i -> no done/err pulse for the aborted run; the new run starts again from entry 0.
6. num_cmds=0 -> no AW or W traffic, polling starts immediately. start_i pulsed while busy -> ignored, exactly one completion pulse.
